scsa_vl_wrap: RTL and testbench
===============================

Name: scsa_vl_wrap

Overview:
Variable-latency wrapper around the 16-bit SCSA speculative carry-select adder. It registers incoming operands and drives them to SCSA, then samples the approximate sum. It detects carry misspeculation and either forwards the SCSA result (1 compute cycle) or substitutes the exact sum (2 compute cycles). It is both the upstream feeder and the downstream consumer of SCSA, with valid/ready on both sides plus saturating error statistics.

Parameters:
WIDTH, 16, operand/sum width; must equal the SCSA width.
BLK, 4, SCSA carry-select block width; WIDTH % BLK == 0; NBLK = WIDTH/BLK.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  operand valid.
in_ready  out  1  wrapper can accept operands.
A_in  in  WIDTH  operand A.
B_in  in  WIDTH  operand B.
Cin_in  in  1  carry-in.
A_I  out  WIDTH  registered A, drives SCSA.A_I.
B_I  out  WIDTH  registered B, drives SCSA.B_I.
Co_Iin  out  1  registered carry-in, drives SCSA.Co_Iin.
S_I  in  WIDTH  SCSA approximate sum (combinational from A_I/B_I/Co_Iin).
Co_I  in  1  SCSA approximate carry-out.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
sum_o  out  WIDTH  exact sum.
cout_o  out  1  exact carry-out.
corrected_o  out  1  result came from the FIX path.
op_cnt  out  CNT_W  completed operations, saturating.
err_cnt  out  CNT_W  misspeculations, saturating.

Behaviour:
- Reset (async, any state, mid-operation included): state=IDLE; A_I/B_I/Co_Iin, sum_o, cout_o, corrected_o, op_cnt, err_cnt = 0; out_valid=0; in_ready=1 after reset deasserts. An in-flight operation is discarded.
- States: IDLE, CHECK, FIX, OUT.
- IDLE: in_ready=1. If in_valid, capture A_in/B_in/Cin_in into A_I/B_I/Co_Iin and go to CHECK.
- CHECK: in_ready=0. Per block k: G_k = carry-out of block k with cin=0; P_k = &(A^B) over block k. Speculated carry c_0 = Co_Iin; c_k = G_{k-1} for k≥1. err = OR over k=1..NBLK of (P_{k-1} & c_{k-1}). This flag is exact: no false positives or negatives versus the SCSA output.
  - err=0: sum_o<=S_I, cout_o<=Co_I, corrected_o<=0, go to OUT.
  - err=1: go to FIX, err_cnt += 1 (saturating).
- FIX: sum_o/cout_o <= exact {carry,sum} of A_I+B_I+Co_Iin (full ripple from the registered operands, single cycle); corrected_o<=1; go to OUT.
- OUT: out_valid=1; sum_o/cout_o/corrected_o held stable until handshake; in_ready=out_ready.
  - On out_valid&out_ready: op_cnt += 1 (saturating). If in_valid in the same cycle, capture new operands and go to CHECK (back-to-back); else go to IDLE.
- Latency from accepting edge to out_valid: 2 edges (clean), 3 edges (corrected). Maximum throughput is one op per 2 cycles, or per 3 when correcting.
- Counters saturate at all-ones; they never wrap.
- A_I/B_I/Co_Iin change only on an accepting edge; they are stable through CHECK, FIX and OUT.

Decomposition:
- Shared package scsa_pkg: state enum (IDLE, CHECK, FIX, OUT), the NBLK derivation, and the width-check constant.
- One combinational sub-module, scsa_spec_check (A, B, cin -> err, per-block G/P), reused by any future SCSA variant.

Test Plan:
- A=0x0007, B=0x0003, Cin=0 -> sum 0x000A, cout 0, corrected 0, out_valid 2 cycles after accept, err_cnt 0.
- A=0x00FF, B=0x0001, Cin=0 -> SCSA S_I=0x0000 and err=1 (P1 & G0); sum_o=0x0100, corrected 1, 3-cycle latency, err_cnt 1.
- A=0xFFFF, B=0x0000, Cin=1 -> err via P0 & Cin; sum 0x0000, cout 1, corrected 1.
- Hold out_ready=0 for 5 cycles in OUT -> out_valid and sum_o stable; in_ready=0. Then raise out_ready with in_valid high -> back-to-back accept, state CHECK next cycle.
- Assert rst during FIX -> outputs zero immediately (async), no out_valid, counters cleared.
- Force op_cnt to 0xFFFF via 65536 clean ops (or a CNT_W=4 build with 16 ops) -> further ops leave the counter at all-ones.

Source files
------------

// File: rtl/scsa_pkg.sv
// Shared SCSA definitions: wrapper FSM states, block-count derivation and width legality check.
// Pure types/constants; no logic, no latency, no flow control.
package scsa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FIX   = 2'd2,
        OUT   = 2'd3
    } state_e;

    function automatic int calc_nblk(input int width, input int blk);
        return width / blk;
    endfunction

    function automatic bit width_ok(input int width, input int blk);
        return (blk > 0) && (width >= blk) && ((width % blk) == 0);
    endfunction

    localparam int SCSA_WIDTH    = 16;
    localparam int SCSA_BLK      = 4;
    localparam int SCSA_NBLK     = calc_nblk(SCSA_WIDTH, SCSA_BLK);
    localparam bit SCSA_WIDTH_OK = width_ok(SCSA_WIDTH, SCSA_BLK);

endpackage

// File: rtl/scsa_spec_check.sv
// Per-block generate/propagate and exact carry-misspeculation flag for a speculative carry-select adder.
// Purely combinational; zero latency, no flow control.
module scsa_spec_check
    import scsa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 cin_i,
    output logic                 err_o,
    output logic [WIDTH/BLK-1:0] g_o,
    output logic [WIDTH/BLK-1:0] p_o
);

    localparam int NBLK = calc_nblk(WIDTH, BLK);

    logic [NBLK-1:0] c_spec;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        logic [BLK:0] raw;
        assign raw    = {1'b0, a_i[k*BLK +: BLK]} + {1'b0, b_i[k*BLK +: BLK]};
        assign g_o[k] = raw[BLK];
        assign p_o[k] = &(a_i[k*BLK +: BLK] ^ b_i[k*BLK +: BLK]);
        // Speculated carry into block k: real cin for block 0, else the lower block's cin=0 carry-out.
        if (k == 0) begin : g_first
            assign c_spec[k] = cin_i;
        end else begin : g_rest
            assign c_spec[k] = g_o[k-1];
        end
    end

    // A guess is wrong only when a fully propagating block receives a carry of 1.
    assign err_o = |(p_o & c_spec);

endmodule

// File: rtl/scsa_vl_wrap.sv
// Variable-latency SCSA wrapper: registers operands, checks speculation, forwards or corrects the sum.
// Accept-to-valid 2 edges (clean) / 3 edges (corrected); result held until out_ready, in_ready follows out_ready in OUT.
module scsa_vl_wrap
    import scsa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             Cin_in,
    output logic [WIDTH-1:0] A_I,
    output logic [WIDTH-1:0] B_I,
    output logic             Co_Iin,
    input  logic [WIDTH-1:0] S_I,
    input  logic             Co_I,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             corrected_o,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int NBLK = calc_nblk(WIDTH, BLK);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if (!width_ok(WIDTH, BLK)) begin : g_bad_width
        $error("scsa_vl_wrap: WIDTH must be a non-zero multiple of BLK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             c_q, c_d, cout_q, cout_d, corr_q, corr_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d, err_cnt_q, err_cnt_d;

    logic             spec_err;
    logic [NBLK-1:0]  blk_g, blk_p;
    logic [NBLK:0]    c_ex;
    logic [WIDTH-1:0] ex_sum;

    scsa_spec_check #(
        .WIDTH (WIDTH),
        .BLK   (BLK)
    ) u_spec_check (
        .a_i   (a_q),
        .b_i   (b_q),
        .cin_i (c_q),
        .err_o (spec_err),
        .g_o   (blk_g),
        .p_o   (blk_p)
    );

    // Exact block carries rippled from the same G/P, so the FIX sum needs no second adder chain.
    always_comb begin
        c_ex    = '0;
        ex_sum  = '0;
        c_ex[0] = c_q;
        for (int k = 0; k < NBLK; k++) begin
            c_ex[k+1]             = blk_g[k] | (blk_p[k] & c_ex[k]);
            ex_sum[k*BLK +: BLK]  = a_q[k*BLK +: BLK] + b_q[k*BLK +: BLK]
                                  + {{(BLK-1){1'b0}}, c_ex[k]};
        end
    end

    assign in_ready    = (state_q == IDLE) || ((state_q == OUT) && out_ready);
    assign out_valid   = (state_q == OUT);
    assign A_I         = a_q;
    assign B_I         = b_q;
    assign Co_Iin      = c_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign corrected_o = corr_q;
    assign op_cnt      = op_cnt_q;
    assign err_cnt     = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        corr_d    = corr_q;
        op_cnt_d  = op_cnt_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A_in;
                    b_d     = B_in;
                    c_d     = Cin_in;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (spec_err) begin
                    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_ONE;
                    state_d   = FIX;
                end else begin
                    sum_d   = S_I;
                    cout_d  = Co_I;
                    corr_d  = 1'b0;
                    state_d = OUT;
                end
            end
            FIX: begin
                sum_d   = ex_sum;
                cout_d  = c_ex[NBLK];
                corr_d  = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    op_cnt_d = (&op_cnt_q) ? op_cnt_q : op_cnt_q + CNT_ONE;
                    if (in_valid) begin
                        a_d     = A_in;
                        b_d     = B_in;
                        c_d     = Cin_in;
                        state_d = CHECK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            corr_q    <= 1'b0;
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            corr_q    <= corr_d;
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_scsa_vl_wrap.sv
// Directed bench for scsa_vl_wrap with a behavioural 16-bit/4-bit-block SCSA on the feeder side.
// Built with 4-bit counters so saturation is reachable in a few dozen operations.
module tb_scsa_vl_wrap;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] A_in, B_in, A_I, B_I, S_I, sum_o;
    logic        Cin_in, Co_Iin, Co_I;
    logic        out_valid, out_ready, cout_o, corrected_o;
    logic [3:0]  op_cnt, err_cnt;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [3:0]  exp_op = 4'h0;
    logic [3:0]  exp_err = 4'h0;

    always #5 clk = ~clk;

    scsa_vl_wrap #(
        .WIDTH (16),
        .BLK   (4),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A_in        (A_in),
        .B_in        (B_in),
        .Cin_in      (Cin_in),
        .A_I         (A_I),
        .B_I         (B_I),
        .Co_Iin      (Co_Iin),
        .S_I         (S_I),
        .Co_I        (Co_I),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sum_o       (sum_o),
        .cout_o      (cout_o),
        .corrected_o (corrected_o),
        .op_cnt      (op_cnt),
        .err_cnt     (err_cnt)
    );

    // Speculative adder: each 4-bit block takes the lower block's cin=0 carry-out as its carry-in.
    function automatic logic [16:0] scsa_model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [15:0] s;
        logic [4:0]  t, t0;
        logic        c, g, co;
        s  = '0;
        g  = 1'b0;
        co = 1'b0;
        for (int k = 0; k < 4; k++) begin
            c  = (k == 0) ? cin : g;
            t0 = {1'b0, a[k*4 +: 4]} + {1'b0, b[k*4 +: 4]};
            t  = t0 + {4'b0, c};
            s[k*4 +: 4] = t[3:0];
            co = t[4];
            g  = t0[4];
        end
        return {co, s};
    endfunction

    always_comb {Co_I, S_I} = scsa_model(A_I, B_I, Co_Iin);

    function automatic logic [3:0] sat4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'h1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; leaves it idle after the result handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] es, input logic ec, input logic ecorr, input int elat);
        int lat;
        bit seen;
        A_in     = a;
        B_in     = b;
        Cin_in   = cin;
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("A_I_capture", A_I, a);
        chk("B_I_capture", B_I, b);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("out_valid_timeout", seen, 1);
        chk("latency", lat, elat);
        chk("sum_o", sum_o, es);
        chk("cout_o", cout_o, ec);
        chk("corrected_o", corrected_o, ecorr);
        if (ecorr) exp_err = sat4(exp_err);
        chk("err_cnt", err_cnt, exp_err);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        exp_op = sat4(exp_op);
        chk("op_cnt", op_cnt, exp_op);
        chk("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A_in      = '0;
        B_in      = '0;
        Cin_in    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum_o", sum_o, 0);
        chk("rst_corrected", corrected_o, 0);
        chk("rst_A_I", A_I, 0);
        chk("rst_op_cnt", op_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        run_op(16'h0007, 16'h0003, 1'b0, 16'h000A, 1'b0, 1'b0, 2);
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1, 3);
        run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 3);
        run_op(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 2);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 2);
        run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 2);

        // Stall in OUT with a pending request, then back-to-back accept on the handshake.
        A_in     = 16'h1111;
        B_in     = 16'h2222;
        Cin_in   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A_in = 16'hABCD;
        B_in = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", out_valid, 1);
            chk("stall_sum_o", sum_o, 16'h3333);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_A_I", A_I, 16'h1111);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_op    = sat4(exp_op);
        chk("b2b_out_valid", out_valid, 0);
        chk("b2b_in_ready", in_ready, 0);
        chk("b2b_A_I", A_I, 16'hABCD);
        chk("b2b_op_cnt", op_cnt, exp_op);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_result_valid", out_valid, 1);
        chk("b2b_sum_o", sum_o, 16'hABCE);
        chk("b2b_corrected", corrected_o, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        exp_op    = sat4(exp_op);
        chk("b2b_op_cnt_2", op_cnt, exp_op);

        // Asynchronous reset while in FIX.
        A_in     = 16'h00FF;
        B_in     = 16'h0001;
        Cin_in   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("fix_err_cnt", err_cnt, sat4(exp_err));
        #1 rst = 1'b1;
        #1;
        chk("arst_sum_o", sum_o, 0);
        chk("arst_A_I", A_I, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_op_cnt", op_cnt, 0);
        chk("arst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst     = 1'b0;
        exp_op  = 4'h0;
        exp_err = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_valid", out_valid, 0);
        end
        chk("arst_in_ready", in_ready, 1);

        // Counter saturation.
        for (int i = 0; i < 17; i++) begin
            run_op(16'(i), 16'h0001, 1'b0, 16'(i + 1), 1'b0, 1'b0, 2);
        end
        chk("op_cnt_saturated", op_cnt, 4'hF);
        for (int i = 0; i < 16; i++) begin
            run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1, 3);
        end
        chk("err_cnt_saturated", err_cnt, 4'hF);
        chk("op_cnt_still_sat", op_cnt, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
